serial_alu_sequencer: RTL

- Drives the one-bit ALU slice (inputs a, b, cin, s[2:0]; outputs aluOut, aluCout) bit-serially, LSB first, to execute a WIDTH-bit operation.
- Accepts a request (op, A, B) over a valid/ready handshake, then feeds one operand bit pair per clock to the slice, with the registered carry/borrow fed back on cin.
- Shifts aluOut into a result register and returns result, carry and zero flags over a valid/ready response handshake.
- Sits between the datapath controller and one instance of the one-bit ALU slice.

---
 rtl/alu_seq_pkg.sv | 25 ++
 rtl/serial_alu_sequencer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/alu_seq_pkg.sv
// Shared constants for the bit-serial ALU sequencer: slice opcodes,
// FSM state encodings and the carry/borrow predicate.
package alu_seq_pkg;

   // Slice select values, in the slice's mux order
   localparam logic [2:0] OP_CLR  = 3'd0;
   localparam logic [2:0] OP_ADD  = 3'd1;
   localparam logic [2:0] OP_AND  = 3'd2;
   localparam logic [2:0] OP_OR   = 3'd3;
   localparam logic [2:0] OP_SUB  = 3'd4;
   localparam logic [2:0] OP_XOR  = 3'd5;
   localparam logic [2:0] OP_XNOR = 3'd6;
   localparam logic [2:0] OP_NOT  = 3'd7;

   // Sequencer FSM encodings
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Only ADD (carry) and SUB (borrow) report the chained carry bit
   function automatic logic op_has_carry(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/serial_alu_sequencer.sv
// Bit-serial sequencer for a one-bit ALU slice: accepts (op, A, B), feeds
// operand bits LSB first with the registered carry fed back on cin, and
// returns result/carry/zero over a valid/ready response handshake.
module serial_alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_op,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic             alu_a,
   output logic             alu_b,
   output logic             alu_cin,
   output logic [2:0]       alu_s,
   input  logic             alu_out,
   input  logic             alu_cout,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_carry,
   output logic             rsp_zero
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   logic [1:0]       state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   // Next-state: capture in IDLE, one bit step per edge in RUN, drain in DONE
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               op_d    = req_op;
               a_d     = req_a;
               b_d     = req_b;
               res_d   = {WIDTH{1'b0}};
               carry_d = 1'b0;
               cnt_d   = {CW{1'b0}};
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            // Slice is combinational: its outputs belong to the current LSBs
            res_d   = {alu_out, res_q[WIDTH-1:1]};
            carry_d = alu_cout;
            a_d     = {1'b0, a_q[WIDTH-1:1]};
            b_d     = {1'b0, b_q[WIDTH-1:1]};
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any in-flight operation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         op_q    <= 3'd0;
         a_q     <= {WIDTH{1'b0}};
         b_q     <= {WIDTH{1'b0}};
         res_q   <= {WIDTH{1'b0}};
         carry_q <= 1'b0;
         cnt_q   <= {CW{1'b0}};
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
      end
   end

   // Output decode straight from flops; everything idles at 0 except req_ready
   always_comb begin
      req_ready  = 1'b0;
      alu_a      = 1'b0;
      alu_b      = 1'b0;
      alu_cin    = 1'b0;
      alu_s      = 3'd0;
      rsp_valid  = 1'b0;
      rsp_result = {WIDTH{1'b0}};
      rsp_carry  = 1'b0;
      rsp_zero   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
         end
         ST_RUN: begin
            alu_a   = a_q[0];
            alu_b   = b_q[0];
            alu_cin = carry_q;
            alu_s   = op_q;
         end
         ST_DONE: begin
            rsp_valid  = 1'b1;
            rsp_result = res_q;
            rsp_carry  = op_has_carry(op_q) ? carry_q : 1'b0;
            rsp_zero   = (res_q == {WIDTH{1'b0}});
         end
         default: begin
            req_ready = 1'b0;
         end
      endcase
   end

endmodule
